frv_intc: RTL and testbench

FRV_INTC -- requirements
Module: frv_intc

---
 rtl/frv_intc_if.sv | 22 ++
 rtl/frv_intc.sv | 129 ++++++++++++
 tb/tb_frv_intc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/frv_intc_if.sv
// rtl/frv_intc_if.sv - MMIO register bus and trap handshake bundle for frv_intc.
interface frv_intc_if;
    logic        mmio_en;
    logic        mmio_wen;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_error;
    logic        int_trap_req;
    logic [5:0]  int_trap_cause;
    logic        int_trap_ack;

    modport master (
        output mmio_en, mmio_wen, mmio_addr, mmio_wdata, int_trap_ack,
        input  mmio_rdata, mmio_error, int_trap_req, int_trap_cause
    );

    modport slave (
        input  mmio_en, mmio_wen, mmio_addr, mmio_wdata, int_trap_ack,
        output mmio_rdata, mmio_error, int_trap_req, int_trap_cause
    );
endinterface

// File: rtl/frv_intc.sv
// rtl/frv_intc.sv - external interrupt controller: edge/level channels, fixed priority, claim/complete FSM.
// Define FRV_INTC_SYNC_EN to add a two-flop synchroniser on irq_in.
module frv_intc #(
    parameter int          NUM_IRQ        = 8,
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_FFE0
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mstatus_mie,
    input  logic               mie_meie,
    output logic               mip_meip,
    frv_intc_if.slave          bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] pending, enable, mode, irq_s, irq_q, pending_nxt;
    logic [NUM_IRQ-1:0] pend_en, claim_oh, rise, clr, mode_chg, ack_clr, wdata_n;
    logic [4:0]         claim_id, win_id;
    logic               take;
    logic [31:0]        offset, rd_val;
    logic               in_win, bad_addr, cmp_bad, acc_ok;
    logic               wr_pend, wr_en, wr_mode, wr_cmp;

`ifdef FRV_INTC_SYNC_EN
    logic [NUM_IRQ-1:0] sync1, sync2;
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end
    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    assign pend_en  = pending & enable;
    assign claim_oh = NUM_IRQ'(1) << claim_id;
    assign wdata_n  = bus.mmio_wdata[NUM_IRQ-1:0];

    always_comb begin
        win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend_en[i]) win_id = 5'(i);
    end

    // COMPLETE is only accepted in SERVICE with the matching id; anything else is an error
    always_comb begin
        offset   = bus.mmio_addr & ~MMIO_BASE_MASK;
        in_win   = bus.mmio_en && ((bus.mmio_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
        bad_addr = (offset[1:0] != 2'b00) || (offset > 32'h10) || (bus.mmio_wen && offset == 32'h10);
        cmp_bad  = bus.mmio_wen && (offset == 32'h0C) &&
                   ((state != SERVICE) || (bus.mmio_wdata != {27'b0, claim_id}));
        acc_ok   = in_win && !bad_addr && !cmp_bad;
        wr_pend  = acc_ok && bus.mmio_wen && offset == 32'h00;
        wr_en    = acc_ok && bus.mmio_wen && offset == 32'h04;
        wr_mode  = acc_ok && bus.mmio_wen && offset == 32'h08;
        wr_cmp   = acc_ok && bus.mmio_wen && offset == 32'h0C;
        case (offset)
            32'h00:  rd_val = 32'(pending);
            32'h04:  rd_val = 32'(enable);
            32'h08:  rd_val = 32'(mode);
            32'h0C:  rd_val = {state, 24'b0, 1'b0, claim_id};
            32'h10:  rd_val = 32'(NUM_IRQ);
            default: rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        ack_clr   = '0;
        case (state)
            IDLE: if (mstatus_mie && mie_meie && |pend_en) begin
                state_nxt = REQ;
                take      = 1'b1;
            end
            REQ: if (bus.int_trap_ack) begin
                state_nxt = SERVICE;
                ack_clr   = claim_oh & mode;
            end else if (!mstatus_mie || !mie_meie || !(|(pend_en & claim_oh))) begin
                state_nxt = IDLE;
            end
            SERVICE: if (wr_cmp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge bits: a new rise beats any clear in the same cycle; level bits just track the input
    always_comb begin
        rise        = irq_s & ~irq_q;
        clr         = (wr_pend ? wdata_n : '0) | ack_clr;
        mode_chg    = wr_mode ? (mode ^ wdata_n) : '0;
        pending_nxt = ((mode & ((pending & ~clr) | rise)) | (~mode & irq_s)) & ~mode_chg;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state          <= IDLE;
            pending        <= '0;
            enable         <= '0;
            mode           <= '0;
            irq_q          <= '0;
            claim_id       <= '0;
            mip_meip       <= 1'b0;
            bus.mmio_rdata <= '0;
            bus.mmio_error <= 1'b0;
        end else begin
            state          <= state_nxt;
            pending        <= pending_nxt;
            irq_q          <= irq_s;
            mip_meip       <= |pend_en;
            bus.mmio_rdata <= (acc_ok && !bus.mmio_wen) ? rd_val : 32'h0;
            bus.mmio_error <= in_win && !acc_ok;
            if (wr_en)   enable   <= wdata_n;
            if (wr_mode) mode     <= wdata_n;
            if (take)    claim_id <= win_id;
        end
    end

    assign bus.int_trap_req   = (state == REQ);
    assign bus.int_trap_cause = (state == REQ) ? (6'd16 + {1'b0, claim_id}) : 6'd0;
endmodule

// File: tb/tb_frv_intc.sv
// tb/tb_frv_intc.sv - scoreboard bench for frv_intc (request latency follows FRV_INTC_SYNC_EN).
module tb_frv_intc;
`ifdef FRV_INTC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] A_PEND = 32'h2000, A_EN = 32'h2004, A_MODE = 32'h2008;
    localparam logic [31:0] A_CMP  = 32'h200C, A_NUM = 32'h2010;
    localparam logic [31:0] SVC    = 32'h8000_0000;

    logic       g_clk = 1'b0;
    logic       g_reset;
    logic [7:0] irq_in;
    logic       mstatus_mie, mie_meie, mip_meip;

    frv_intc_if bus();

    frv_intc dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .irq_in      (irq_in),
        .mstatus_mie (mstatus_mie),
        .mie_meie    (mie_meie),
        .mip_meip    (mip_meip),
        .bus         (bus)
    );

    always #5 g_clk = ~g_clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [32:0] mq[$];
    logic [5:0]  cq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic mmio(input string tag, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        logic [32:0] e;
        bus.mmio_en    = 1'b1;
        bus.mmio_wen   = wen;
        bus.mmio_addr  = addr;
        bus.mmio_wdata = wdata;
        mq.push_back({exp_err, exp_rd});
        tick();
        bus.mmio_en  = 1'b0;
        bus.mmio_wen = 1'b0;
        e = mq.pop_front();
        check({tag, " rdata"}, bus.mmio_rdata, e[31:0]);
        check({tag, " error"}, 32'(bus.mmio_error), 32'(e[32]));
    endtask

    task automatic expect_req(input string tag, input int lat);
        int         cnt;
        logic [5:0] e;
        cnt = 0;
        while (!bus.int_trap_req && cnt < 20) begin
            tick();
            cnt++;
        end
        e = cq.pop_front();
        check({tag, " req"}, 32'(bus.int_trap_req), 32'd1);
        if (bus.int_trap_req) begin
            check({tag, " cause"}, 32'(bus.int_trap_cause), 32'(e));
            if (lat >= 0) check({tag, " latency"}, cnt, lat);
        end
    endtask

    task automatic ack_once();
        bus.int_trap_ack = 1'b1;
        tick();
        bus.int_trap_ack = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " req"},   32'(bus.int_trap_req),   32'd0);
        check({tag, " cause"}, 32'(bus.int_trap_cause), 32'd0);
        check({tag, " mip"},   32'(mip_meip),           32'd0);
        check({tag, " rdata"}, bus.mmio_rdata,          32'd0);
        check({tag, " error"}, 32'(bus.mmio_error),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        g_reset = 1'b1;
        irq_in = '0;
        mstatus_mie = 1'b0;
        mie_meie = 1'b0;
        bus.mmio_en = 1'b0;
        bus.mmio_wen = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_wdata = '0;
        bus.int_trap_ack = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        g_reset = 1'b0;
        mmio("rst enable", 1'b0, A_EN, 0, 32'h0, 1'b0);
        mmio("num", 1'b0, A_NUM, 0, 32'd8, 1'b0);
        mmio("wr enable", 1'b1, A_EN, 32'hFF, 32'h0, 1'b0);
        mmio("wr mode", 1'b1, A_MODE, 32'h00, 32'h0, 1'b0);
        mmio("rd enable", 1'b0, A_EN, 0, 32'hFF, 1'b0);
        mstatus_mie = 1'b1;
        mie_meie = 1'b1;

        // single level channel
        irq_in[3] = 1'b1;
        cq.push_back(6'd19);
        expect_req("s1", LAT);
        check("s1 mip", 32'(mip_meip), 32'd1);
        tick();
        tick();
        check("s1 hold req", 32'(bus.int_trap_req), 32'd1);
        check("s1 hold cause", 32'(bus.int_trap_cause), 32'd19);
        ack_once();
        irq_in[3] = 1'b0;
        check("s1 req after ack", 32'(bus.int_trap_req), 32'd0);
        mmio("s1 svc", 1'b0, A_CMP, 0, SVC | 32'd3, 1'b0);
        repeat (4) tick();
        mmio("s1 complete", 1'b1, A_CMP, 32'd3, 32'h0, 1'b0);
        mmio("s1 idle", 1'b0, A_CMP, 0, 32'd3, 1'b0);

        // priority between two simultaneous channels
        irq_in[2] = 1'b1;
        irq_in[5] = 1'b1;
        cq.push_back(6'd18);
        expect_req("s2a", LAT);
        ack_once();
        irq_in[2] = 1'b0;
        repeat (4) tick();
        mmio("s2 complete2", 1'b1, A_CMP, 32'd2, 32'h0, 1'b0);
        cq.push_back(6'd21);
        expect_req("s2b", -1);
        ack_once();
        irq_in[5] = 1'b0;
        repeat (4) tick();
        mmio("s2 complete5", 1'b1, A_CMP, 32'd5, 32'h0, 1'b0);

        // edge channel: latch, ack clear, W1C clear
        mmio("s3 mode", 1'b1, A_MODE, 32'h02, 32'h0, 1'b0);
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        repeat (4) tick();
        mmio("s3 pend latched", 1'b0, A_PEND, 0, 32'h02, 1'b0);
        cq.push_back(6'd17);
        expect_req("s3", -1);
        ack_once();
        mmio("s3 pend after ack", 1'b0, A_PEND, 0, 32'h00, 1'b0);
        mmio("s3 complete", 1'b1, A_CMP, 32'd1, 32'h0, 1'b0);
        mstatus_mie = 1'b0;
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        repeat (4) tick();
        mmio("s3 pend idle", 1'b0, A_PEND, 0, 32'h02, 1'b0);
        mmio("s3 w1c", 1'b1, A_PEND, 32'h02, 32'h0, 1'b0);
        mmio("s3 pend w1c", 1'b0, A_PEND, 0, 32'h00, 1'b0);
        mstatus_mie = 1'b1;
        mmio("s3 mode back", 1'b1, A_MODE, 32'h00, 32'h0, 1'b0);

        // withdraw on mie drop, and ack winning over the drop
        irq_in[4] = 1'b1;
        cq.push_back(6'd20);
        expect_req("s4a", -1);
        mstatus_mie = 1'b0;
        tick();
        check("s4 withdraw req", 32'(bus.int_trap_req), 32'd0);
        mmio("s4 idle", 1'b0, A_CMP, 0, 32'd4, 1'b0);
        mstatus_mie = 1'b1;
        cq.push_back(6'd20);
        expect_req("s4b", -1);
        mstatus_mie = 1'b0;
        ack_once();
        check("s4 ack wins req", 32'(bus.int_trap_req), 32'd0);
        mmio("s4 svc", 1'b0, A_CMP, 0, SVC | 32'd4, 1'b0);
        mstatus_mie = 1'b1;
        irq_in[4] = 1'b0;
        repeat (4) tick();
        mmio("s4 complete", 1'b1, A_CMP, 32'd4, 32'h0, 1'b0);

        // bad completion and bad addresses
        irq_in[3] = 1'b1;
        cq.push_back(6'd19);
        expect_req("s5", -1);
        ack_once();
        irq_in[3] = 1'b0;
        repeat (4) tick();
        mmio("s5 bad complete", 1'b1, A_CMP, 32'd7, 32'h0, 1'b1);
        mmio("s5 still svc", 1'b0, A_CMP, 0, SVC | 32'd3, 1'b0);
        mmio("s5 off 0x14", 1'b0, 32'h2014, 0, 32'h0, 1'b1);
        mmio("s5 misaligned", 1'b0, 32'h2002, 0, 32'h0, 1'b1);
        mmio("s5 wr num", 1'b1, A_NUM, 32'd3, 32'h0, 1'b1);
        mmio("s5 out of window", 1'b0, 32'h3004, 0, 32'h0, 1'b0);

        // reset while in SERVICE
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        check_quiet("s6 reset");
        mmio("s6 enable", 1'b0, A_EN, 0, 32'h0, 1'b0);
        mmio("s6 state", 1'b0, A_CMP, 0, 32'h0, 1'b0);
        mmio("s6 mode", 1'b0, A_MODE, 0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
